ysyx_040750_ifetch_axi: RTL and testbench

Instruction-fetch bus master directly upstream of the IF/PC stage. Accepts one fetch request per handshake (PC stage's next-PC plus request-valid) and issues an AXI4-lite read. It returns the selected 32-bit instruction as a one-cycle valid pulse into the PC stage's inst/inst_valid inputs, and its ready output drives the PC stage's inst_ready. Flush / fence.i discard any in-flight response while keeping the AXI protocol legal.

---
 rtl/ysyx_040750_ifetch_axi.sv | 195 +++++++++++++++++++
 tb/tb_ysyx_040750_ifetch_axi.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040750_ifetch_axi.sv
// Instruction-fetch AXI4-lite read master sitting in front of the IF/PC stage.
//
// Takes one fetch request per handshake. For each request it issues a single AXI read and
// returns the selected 32-bit instruction as a one-cycle pulse on O_inst_valid. I_flush and
// I_fencei drop any response that is in flight. The AXI transaction still finishes normally,
// so the protocol stays legal.
//
// Optional feature: define YSYX_040750_IFETCH_LINEBUF_EN to enable a one-entry line buffer.
// It holds the last good beat. A request that hits the buffer returns its data one cycle
// later and issues no AR. I_fencei invalidates the buffer.
//
// Ports:
//   I_sys_clk, I_rst_n                       clock, asynchronous active-low reset
//   I_req_valid, I_req_addr, O_req_ready     fetch request handshake
//   I_flush, I_fencei                        drop the outstanding response
//   O_inst, O_inst_valid, O_fetch_err        fetched instruction (one-cycle pulse)
//   O_araddr, O_arvalid, I_arready           AXI AR channel
//   I_rdata, I_rresp, I_rvalid, O_rready     AXI R channel
module ysyx_040750_ifetch_axi #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic              I_sys_clk,
  input  logic              I_rst_n,
  input  logic              I_req_valid,
  input  logic [ADDR_W-1:0] I_req_addr,
  output logic              O_req_ready,
  input  logic              I_flush,
  input  logic              I_fencei,
  output logic [31:0]       O_inst,
  output logic              O_inst_valid,
  output logic              O_fetch_err,
  output logic [ADDR_W-1:0] O_araddr,
  output logic              O_arvalid,
  input  logic              I_arready,
  input  logic [DATA_W-1:0] I_rdata,
  input  logic [1:0]        I_rresp,
  input  logic              I_rvalid,
  output logic              O_rready
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              fetch_err_q, fetch_err_d;

  logic [ADDR_W-1:0] req_aligned;
  logic              req_sel;
  logic              kill;
  logic [63:0]       rdata_ext;
  logic [31:0]       beat_word;
  logic              lb_hit;
  logic [31:0]       lb_word;

  assign req_aligned = {I_req_addr[ADDR_W-1:OffW], {OffW{1'b0}}};
  // With a 32-bit bus every beat is a single instruction, so there is no half to pick.
  assign req_sel     = (DATA_W == 64) ? I_req_addr[2] : 1'b0;
  assign kill        = I_flush | I_fencei;
  // Zero-extend so the upper-half slice is legal for both bus widths.
  assign rdata_ext   = 64'(I_rdata);
  assign beat_word   = sel_q ? rdata_ext[63:32] : rdata_ext[31:0];

`ifdef YSYX_040750_IFETCH_LINEBUF_EN
  logic              lb_valid_q, lb_valid_d;
  logic [ADDR_W-1:0] lb_addr_q, lb_addr_d;
  logic [DATA_W-1:0] lb_data_q, lb_data_d;
  logic [63:0]       lb_ext;

  assign lb_ext  = 64'(lb_data_q);
  assign lb_word = req_sel ? lb_ext[63:32] : lb_ext[31:0];
  // A fence.i in the same cycle already invalidates the entry, so it must not hit.
  assign lb_hit  = lb_valid_q && !I_fencei && (lb_addr_q == req_aligned);

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      lb_valid_q <= 1'b0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
    end else begin
      lb_valid_q <= lb_valid_d;
      lb_addr_q  <= lb_addr_d;
      lb_data_q  <= lb_data_d;
    end
  end
`else
  assign lb_hit  = 1'b0;
  assign lb_word = '0;
`endif

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    sel_d        = sel_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    fetch_err_d  = 1'b0;
`ifdef YSYX_040750_IFETCH_LINEBUF_EN
    lb_valid_d   = lb_valid_q && !I_fencei;
    lb_addr_d    = lb_addr_q;
    lb_data_d    = lb_data_q;
`endif

    case (state_q)
      StIdle: begin
        if (I_req_valid) begin
          if (lb_hit) begin
            inst_d       = lb_word;
            inst_valid_d = 1'b1;
          end else begin
            sel_d     = req_sel;
            araddr_d  = req_aligned;
            arvalid_d = 1'b1;
            drop_d    = 1'b0;
            state_d   = StAr;
          end
        end
      end
      StAr: begin
        if (kill) drop_d = 1'b1;
        if (I_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StR;
        end
      end
      StR: begin
        if (kill) drop_d = 1'b1;
        if (I_rvalid) begin
          rready_d = 1'b0;
          state_d  = StIdle;
          if (!drop_q && !kill) begin
            inst_valid_d = 1'b1;
            if (I_rresp != 2'b00) begin
              fetch_err_d = 1'b1;
              inst_d      = 32'd0;
            end else begin
              inst_d = beat_word;
`ifdef YSYX_040750_IFETCH_LINEBUF_EN
              lb_valid_d = 1'b1;
              lb_addr_d  = araddr_q;
              lb_data_d  = I_rdata;
`endif
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= StIdle;
      drop_q       <= 1'b0;
      sel_q        <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      sel_q        <= sel_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  assign O_req_ready  = (state_q == StIdle);
  assign O_inst       = inst_q;
  assign O_inst_valid = inst_valid_q;
  assign O_fetch_err  = fetch_err_q;
  assign O_araddr     = araddr_q;
  assign O_arvalid    = arvalid_q;
  assign O_rready     = rready_q;

endmodule

// File: tb/tb_ysyx_040750_ifetch_axi.sv
// Self-checking bench for ysyx_040750_ifetch_axi.
// The driver issues fetches and plays the AXI slave. It also pushes the expected instruction
// for each fetch into a queue. An independent monitor pops that queue on every O_inst_valid
// pulse and compares.
module tb_ysyx_040750_ifetch_axi;

`ifdef YSYX_040750_IFETCH_LINEBUF_EN
  localparam bit LbEn = 1'b1;
`else
  localparam bit LbEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        fencei = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  ysyx_040750_ifetch_axi #(.ADDR_W(32), .DATA_W(64)) dut (
    .I_sys_clk   (clk),
    .I_rst_n     (rst_n),
    .I_req_valid (req_valid),
    .I_req_addr  (req_addr),
    .O_req_ready (req_ready),
    .I_flush     (flush),
    .I_fencei    (fencei),
    .O_inst      (inst),
    .O_inst_valid(inst_valid),
    .O_fetch_err (fetch_err),
    .O_araddr    (araddr),
    .O_arvalid   (arvalid),
    .I_arready   (arready),
    .I_rdata     (rdata),
    .I_rresp     (rresp),
    .I_rvalid    (rvalid),
    .O_rready    (rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference line buffer (only consulted when the feature is built in).
  bit          m_lb_valid = 1'b0;
  logic [31:0] m_lb_addr  = '0;
  logic [63:0] m_lb_data  = '0;

  // Pulse expected (or not) in the cycle a new operation starts.
  bit pend_chk = 1'b0;
  bit pend_val = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Checks made in any idle cycle before a new operation is driven.
  task automatic idle_checks();
    chk("arvalid_idle", arvalid, 1'b0);
    chk("rready_idle", rready, 1'b0);
    chk("req_ready_idle", req_ready, 1'b1);
    if (pend_chk) chk("inst_valid_timing", inst_valid, pend_val);
    pend_chk = 1'b0;
  endtask

  // Monitor: every output pulse must match the oldest expected entry.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (fetch_err && !inst_valid) chk("fetch_err_alone", fetch_err, 1'b0);
      if (inst_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got %0h expected no pulse at %0t", inst, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("inst", inst, mon_e.inst);
          chk("fetch_err", fetch_err, mon_e.err);
        end
      end
    end
  end

  // One fetch. kill_at > 0 drops the fetch with a flush/fence.i pulse that many cycles after
  // accept. Zero-wait timing: accept at cycle 0, AR at 1, R at 2, pulse at 3.
  task automatic do_fetch(input logic [31:0] addr, input logic [63:0] data, input int ar_dly,
                          input int r_dly, input logic [1:0] resp, input int kill_at,
                          input bit use_fencei, input bit flush_on_accept);
    logic [31:0] aligned;
    logic [31:0] word;
    bit          hit;
    bit          dropped;
    int          c;
    exp_t        e;
    aligned = {addr[31:3], 3'b000};
    word    = addr[2] ? data[63:32] : data[31:0];
    hit     = LbEn && m_lb_valid && (m_lb_addr == aligned);
    dropped = (kill_at > 0);

    req_valid = 1'b1;
    req_addr  = addr;
    flush     = flush_on_accept;
    fencei    = 1'b0;
    @(negedge clk);
    idle_checks();
    if (hit) begin
      e.inst = addr[2] ? m_lb_data[63:32] : m_lb_data[31:0];
      e.err  = 1'b0;
      exp_q.push_back(e);
    end else if (!dropped) begin
      e.err  = (resp != 2'b00);
      e.inst = e.err ? 32'd0 : word;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;

    if (hit) begin
      pend_chk = 1'b1;
      pend_val = 1'b1;
      return;
    end

    c = 1;
    for (int i = 0; i <= ar_dly; i++) begin
      arready = (i == ar_dly);
      flush   = (c == kill_at) && !use_fencei;
      fencei  = (c == kill_at) && use_fencei;
      @(negedge clk);
      chk("arvalid_held", arvalid, 1'b1);
      chk("araddr", araddr, aligned);
      chk("req_ready_busy", req_ready, 1'b0);
      @(posedge clk);
      #1;
      c++;
    end
    arready = 1'b0;
    for (int i = 0; i <= r_dly; i++) begin
      rvalid = (i == r_dly);
      rdata  = rvalid ? data : {$urandom, $urandom};
      rresp  = rvalid ? resp : 2'(($urandom_range(0, 3)));
      flush  = (c == kill_at) && !use_fencei;
      fencei = (c == kill_at) && use_fencei;
      @(negedge clk);
      chk("rready", rready, 1'b1);
      chk("arvalid_r", arvalid, 1'b0);
      chk("req_ready_r", req_ready, 1'b0);
      @(posedge clk);
      #1;
      c++;
    end
    rvalid = 1'b0;
    flush  = 1'b0;
    fencei = 1'b0;

    if (!dropped && resp == 2'b00) begin
      m_lb_valid = 1'b1;
      m_lb_addr  = aligned;
      m_lb_data  = data;
    end
    if (dropped && use_fencei) m_lb_valid = 1'b0;
    pend_chk = 1'b1;
    pend_val = !dropped;
  endtask

  task automatic idle_cycle(input bit with_fencei);
    req_valid = 1'b0;
    fencei    = with_fencei;
    @(negedge clk);
    idle_checks();
    @(posedge clk);
    #1;
    fencei = 1'b0;
    if (with_fencei) m_lb_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ar_d, r_d, k;
    logic [1:0] rsp;

    // Reset values while held in reset.
    #3;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_fetch_err", fetch_err, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic fetches: low half, high half, withheld arready with flush, error response.
    do_fetch(32'h3000_0000, 64'h00000013_00100093, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    do_fetch(32'h3000_0004, 64'h00000013_00100093, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    do_fetch(32'h3000_0008, 64'h11111111_22222222, 4, 0, 2'b00, 2, 1'b0, 1'b0);
    idle_cycle(1'b0);
    do_fetch(32'h3000_0010, 64'h33333333_44444444, 0, 0, 2'b10, 0, 1'b0, 1'b0);

    // Line-buffer sequence: fill, re-read other half, fence.i, re-read must go to AXI.
    do_fetch(32'h3000_0000, 64'h00000013_00100093, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    do_fetch(32'h3000_0004, 64'h00000013_00100093, 0, 0, 2'b00, 0, 1'b0, 1'b0);
    idle_cycle(1'b1);
    do_fetch(32'h3000_0004, 64'h00000013_00100093, 1, 1, 2'b00, 0, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Asynchronous reset in the R phase.
    req_valid = 1'b1;
    req_addr  = 32'h3000_0018;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    arready   = 1'b1;
    @(posedge clk);
    #1;
    arready = 1'b0;
    @(negedge clk);
    chk("rst_test_rready", rready, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rready", rready, 1'b0);
    chk("async_arvalid", arvalid, 1'b0);
    chk("async_inst_valid", inst_valid, 1'b0);
    chk("async_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    m_lb_valid = 1'b0;
    pend_chk   = 1'b0;

    // Randomized fetches.
    for (int n = 0; n < 300; n++) begin
      ar_d = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      r_d  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      rsp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      k    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, ar_d + r_d + 2)) : 0;
      do_fetch(32'h3000_0000 + 32'($urandom_range(0, 7)) * 4, {$urandom, $urandom}, ar_d, r_d,
               rsp, k, $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 5) == 0) idle_cycle($urandom_range(0, 3) == 0);
    end
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
